// File: rtl/mem_cache.sv
// Direct-mapped, write-through, write-allocate word cache between the memory-access worker and memory.
// Optional hit/miss counters are compiled in with `define MEM_CACHE_STATS_EN.
module mem_cache #(
    parameter int INDEX_WIDTH = 6,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic                  REQ_DATA_VALID,
    input  logic [31:0]           REQ_DATA,
    output logic                  REQ_READY,
    output logic                  RESP_VALID,
    output logic [31:0]           RESP_DATA,
    input  logic                  RESP_READY,
    output logic                  MEM_SEND_ADDR_VALID,
    output logic [ADDR_WIDTH-1:0] MEM_SEND_ADDR,
    output logic                  MEM_SEND_DATA_VALID,
    output logic [31:0]           MEM_SEND_DATA,
    input  logic                  MEM_SEND_READY,
    input  logic                  MEM_RECEIVE_VALID,
    input  logic [31:0]           MEM_RECEIVE_DATA,
    output logic                  MEM_RECEIVE_READY
`ifdef MEM_CACHE_STATS_EN
    ,
    output logic [31:0]           HIT_COUNT,
    output logic [31:0]           MISS_COUNT
`endif
);
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH;
    localparam int LINES = 1 << INDEX_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MEM_SEND, S_MEM_RECEIVE, S_RESP
    } state_t;

    state_t                  r_state;
    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag  [LINES];
    logic [31:0]             r_word [LINES];
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic                    r_wr;
    logic [INDEX_WIDTH-1:0]  r_idx;

    logic [TAG_W-1:0]        w_tag;
    logic                    w_hit;
    logic                    w_fill;
    logic [31:0]             w_word;

    assign w_tag  = r_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign w_hit  = r_valid[r_idx] && (r_tag[r_idx] == w_tag);
    assign w_fill = (r_state == S_MEM_RECEIVE) && MEM_RECEIVE_VALID && MEM_RECEIVE_READY;
    // Writes allocate with the requester's data; memory's write ack word is ignored.
    assign w_word = r_wr ? r_wdata : MEM_RECEIVE_DATA;

    // Line payload needs no reset: the valid bits gate every use of it.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[r_idx]  <= w_tag;
            r_word[r_idx] <= w_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state             <= S_IDLE;
            r_valid             <= '0;
            r_addr              <= '0;
            r_wdata             <= '0;
            r_wr                <= 1'b0;
            r_idx               <= '0;
            REQ_READY           <= 1'b0;
            RESP_VALID          <= 1'b0;
            RESP_DATA           <= '0;
            MEM_SEND_ADDR_VALID <= 1'b0;
            MEM_SEND_ADDR       <= '0;
            MEM_SEND_DATA_VALID <= 1'b0;
            MEM_SEND_DATA       <= '0;
            MEM_RECEIVE_READY   <= 1'b0;
`ifdef MEM_CACHE_STATS_EN
            HIT_COUNT           <= '0;
            MISS_COUNT          <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (REQ_ADDR_VALID && REQ_READY) begin
                        r_addr    <= REQ_ADDR;
                        r_wdata   <= REQ_DATA;
                        r_wr      <= REQ_DATA_VALID;
                        r_idx     <= REQ_ADDR[INDEX_WIDTH-1:0];
                        REQ_READY <= 1'b0;
                        r_state   <= S_LOOKUP;
                    end else begin
                        REQ_READY <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (!r_wr && w_hit) begin
                        RESP_DATA  <= r_word[r_idx];
                        RESP_VALID <= 1'b1;
                        r_state    <= S_RESP;
`ifdef MEM_CACHE_STATS_EN
                        if (HIT_COUNT != '1) HIT_COUNT <= HIT_COUNT + 32'd1;
`endif
                    end else begin
                        MEM_SEND_ADDR_VALID <= 1'b1;
                        MEM_SEND_ADDR       <= r_addr;
                        MEM_SEND_DATA_VALID <= r_wr;
                        MEM_SEND_DATA       <= r_wdata;
                        r_state             <= S_MEM_SEND;
`ifdef MEM_CACHE_STATS_EN
                        if (!r_wr && MISS_COUNT != '1) MISS_COUNT <= MISS_COUNT + 32'd1;
`endif
                    end
                end
                S_MEM_SEND: begin
                    if (MEM_SEND_READY) begin
                        MEM_SEND_ADDR_VALID <= 1'b0;
                        MEM_SEND_DATA_VALID <= 1'b0;
                        MEM_RECEIVE_READY   <= 1'b1;
                        r_state             <= S_MEM_RECEIVE;
                    end
                end
                S_MEM_RECEIVE: begin
                    if (MEM_RECEIVE_VALID) begin
                        MEM_RECEIVE_READY <= 1'b0;
                        r_valid[r_idx]    <= 1'b1;
                        RESP_DATA         <= w_word;
                        RESP_VALID        <= 1'b1;
                        r_state           <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (RESP_READY) begin
                        RESP_VALID <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_cache.sv
// Self-checking bench for mem_cache: directed vector table, reset/stats sequences, then random traffic
// checked against an address-keyed cache/memory model.
module tb_mem_cache;
    localparam int AW = 32;
    localparam int IW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_ADDR_VALID, REQ_DATA_VALID, REQ_READY;
    logic [AW-1:0] REQ_ADDR;
    logic [31:0]   REQ_DATA;
    logic          RESP_VALID, RESP_READY;
    logic [31:0]   RESP_DATA;
    logic          MEM_SEND_ADDR_VALID, MEM_SEND_DATA_VALID, MEM_SEND_READY;
    logic [AW-1:0] MEM_SEND_ADDR;
    logic [31:0]   MEM_SEND_DATA;
    logic          MEM_RECEIVE_VALID, MEM_RECEIVE_READY;
    logic [31:0]   MEM_RECEIVE_DATA;
`ifdef MEM_CACHE_STATS_EN
    logic [31:0]   HIT_COUNT, MISS_COUNT;
`endif

    always #5 CLK = ~CLK;

    mem_cache #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_ADDR_VALID(REQ_ADDR_VALID), .REQ_ADDR(REQ_ADDR),
        .REQ_DATA_VALID(REQ_DATA_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
        .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA), .RESP_READY(RESP_READY),
        .MEM_SEND_ADDR_VALID(MEM_SEND_ADDR_VALID), .MEM_SEND_ADDR(MEM_SEND_ADDR),
        .MEM_SEND_DATA_VALID(MEM_SEND_DATA_VALID), .MEM_SEND_DATA(MEM_SEND_DATA),
        .MEM_SEND_READY(MEM_SEND_READY),
        .MEM_RECEIVE_VALID(MEM_RECEIVE_VALID), .MEM_RECEIVE_DATA(MEM_RECEIVE_DATA),
        .MEM_RECEIVE_READY(MEM_RECEIVE_READY)
`ifdef MEM_CACHE_STATS_EN
        , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: backing memory plus a map of which full address each line currently holds.
    logic [31:0] mem_m [logic [31:0]];
    bit          m_valid [64];
    logic [31:0] m_addr  [64];
    logic [31:0] m_word  [64];
    int          m_hits, m_misses;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] data;
        bit          pre;
        logic [31:0] pre_val;
        int          ss;
        int          rs;
        logic [31:0] edata;
        int          nsend;
    } vec_t;
    vec_t tab [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] d,
                                output logic [31:0] expv, output bit hit);
        int i;
        i = int'(a % 64);
        hit = !wr && m_valid[i] && (m_addr[i] == a);
        if (wr) begin
            mem_m[a] = d;
            expv = d;
        end else if (hit) begin
            expv = m_word[i];
        end else begin
            expv = memval(a);
        end
        if (!hit) begin
            m_valid[i] = 1'b1;
            m_addr[i]  = a;
            m_word[i]  = expv;
        end
        if (!wr) begin
            if (hit) m_hits++; else m_misses++;
        end
    endtask

    task automatic idle_inputs();
        REQ_ADDR_VALID = 1'b0; REQ_DATA_VALID = 1'b0; REQ_ADDR = '0; REQ_DATA = '0;
        RESP_READY = 1'b0; MEM_SEND_READY = 1'b0;
        MEM_RECEIVE_VALID = 1'b0; MEM_RECEIVE_DATA = '0;
    endtask

    function automatic logic any_output();
        return |{REQ_READY, RESP_VALID, RESP_DATA, MEM_SEND_ADDR_VALID, MEM_SEND_ADDR,
                 MEM_SEND_DATA_VALID, MEM_SEND_DATA, MEM_RECEIVE_READY};
    endfunction

    // Issues one request (called at a negedge) and plays the memory side; returns the response word,
    // the number of memory sends and the cycle (after the accept edge) in which RESP_VALID first showed.
    task automatic xact(input logic [31:0] a, input bit wr, input logic [31:0] d,
                        input int sstall, input int rstall,
                        output logic [31:0] rdata, output int nsend, output int lat);
        int  cyc;
        bit  done, seen;
        rdata = '0; nsend = 0; lat = 0;
        REQ_ADDR_VALID = 1'b1; REQ_ADDR = a; REQ_DATA_VALID = wr; REQ_DATA = d;
        cyc = 0;
        while (!REQ_READY && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk("req_accept_timeout", 32'(cyc < 20), 32'd1);
        @(negedge CLK);
        REQ_ADDR_VALID = 1'b0; REQ_DATA_VALID = 1'b0;
        done = 1'b0; seen = 1'b0; cyc = 1;
        while (!done && cyc < 100) begin
            MEM_SEND_READY = 1'b0; MEM_RECEIVE_VALID = 1'b0; RESP_READY = 1'b0;
            chk("req_ready_busy", REQ_READY, 0);
            if (RESP_VALID) begin
                if (!seen) begin
                    seen = 1'b1; lat = cyc; rdata = RESP_DATA;
                end else begin
                    chk("resp_stable", RESP_DATA, rdata);
                end
                if (rstall > 0) rstall--;
                else begin
                    RESP_READY = 1'b1;
                    done = 1'b1;
                end
            end else if (MEM_SEND_ADDR_VALID) begin
                chk("send_addr", MEM_SEND_ADDR, a);
                chk("send_is_write", MEM_SEND_DATA_VALID, wr);
                if (wr) chk("send_data", MEM_SEND_DATA, d);
                chk("recv_ready_early", MEM_RECEIVE_READY, 0);
                if (sstall > 0) begin
                    sstall--;
                    // Premature memory response must be ignored.
                    MEM_RECEIVE_VALID = 1'b1; MEM_RECEIVE_DATA = 32'hBAD0BAD0;
                end else begin
                    MEM_SEND_READY = 1'b1;
                    nsend++;
                end
            end else if (MEM_RECEIVE_READY) begin
                MEM_RECEIVE_VALID = 1'b1;
                MEM_RECEIVE_DATA  = wr ? ~d : memval(a);
            end
            @(negedge CLK);
            cyc++;
        end
        MEM_SEND_READY = 1'b0; MEM_RECEIVE_VALID = 1'b0; RESP_READY = 1'b0;
        chk("xact_timeout", 32'(done), 32'd1);
        chk("resp_single_transfer", RESP_VALID, 0);
    endtask

    task automatic run(input logic [31:0] a, input bit wr, input logic [31:0] d, input int ss, input int rs,
                       input bit use_tab, input logic [31:0] tdata, input int tsend);
        logic [31:0] mexp, rdata;
        bit          mhit;
        int          nsend, lat;
        model_access(a, wr, d, mexp, mhit);
        xact(a, wr, d, ss, rs, rdata, nsend, lat);
        chk("resp_data", rdata, use_tab ? tdata : mexp);
        chk("mem_sends", nsend, use_tab ? tsend : (mhit ? 0 : 1));
        if (mhit) chk("hit_latency", lat, 2);
        @(negedge CLK);
        chk("req_ready_b2b", REQ_READY, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [31:0] a;
        tab[0]  = '{32'h41, 0, 32'h0,        1, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1};
        tab[1]  = '{32'h41, 0, 32'h0,        0, 32'h0,        0, 0, 32'hDEADBEEF, 0};
        tab[2]  = '{32'h41, 1, 32'h12345678, 0, 32'h0,        0, 0, 32'h12345678, 1};
        tab[3]  = '{32'h41, 0, 32'h0,        0, 32'h0,        0, 0, 32'h12345678, 0};
        tab[4]  = '{32'h01, 0, 32'h0,        1, 32'h0000AAAA, 0, 0, 32'h0000AAAA, 1};
        tab[5]  = '{32'h41, 0, 32'h0,        1, 32'h0000BBBB, 0, 0, 32'h0000BBBB, 1};
        tab[6]  = '{32'h01, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000AAAA, 1};
        tab[7]  = '{32'h01, 0, 32'h0,        0, 32'h0,        5, 4, 32'h0000AAAA, 0};
        tab[8]  = '{32'h80, 0, 32'h0,        1, 32'h55550000, 5, 4, 32'h55550000, 1};
        tab[9]  = '{32'h81, 1, 32'hCAFEF00D, 0, 32'h0,        2, 1, 32'hCAFEF00D, 1};
        tab[10] = '{32'h81, 0, 32'h0,        0, 32'h0,        0, 0, 32'hCAFEF00D, 0};
        tab[11] = '{32'h01, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000AAAA, 1};

        idle_inputs();
        model_clear();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("reset_outputs", 32'(any_output()), 32'd0);
`ifdef MEM_CACHE_STATS_EN
        chk("reset_hit_count", HIT_COUNT, 0);
        chk("reset_miss_count", MISS_COUNT, 0);
`endif
        RST = 1'b0;
        @(negedge CLK);
        chk("req_ready_after_reset", REQ_READY, 1);

        for (int i = 0; i < 12; i++) begin
            if (tab[i].pre) mem_m[tab[i].addr] = tab[i].pre_val;
            run(tab[i].addr, tab[i].wr, tab[i].data, tab[i].ss, tab[i].rs, 1'b1, tab[i].edata, tab[i].nsend);
        end

        // Reset while waiting for the memory response abandons the request and empties the cache.
        run(32'h41, 0, 32'h0, 0, 0, 1'b0, 32'h0, 0);
        run(32'h41, 0, 32'h0, 0, 0, 1'b0, 32'h0, 0);
        REQ_ADDR_VALID = 1'b1; REQ_ADDR = 32'h50; REQ_DATA_VALID = 1'b0;
        cyc = 0;
        while (!REQ_READY && cyc < 20) begin @(negedge CLK); cyc++; end
        @(negedge CLK);
        REQ_ADDR_VALID = 1'b0;
        cyc = 0;
        while (!MEM_SEND_ADDR_VALID && cyc < 20) begin @(negedge CLK); cyc++; end
        chk("rst_seq_send_seen", MEM_SEND_ADDR_VALID, 1);
        MEM_SEND_READY = 1'b1;
        @(negedge CLK);
        MEM_SEND_READY = 1'b0;
        chk("rst_seq_in_receive", MEM_RECEIVE_READY, 1);
        RST = 1'b1;
        MEM_RECEIVE_VALID = 1'b1; MEM_RECEIVE_DATA = 32'h77777777;
        @(negedge CLK);
        chk("midop_reset_outputs", 32'(any_output()), 32'd0);
        RST = 1'b0;
        MEM_RECEIVE_VALID = 1'b0;
        model_clear();
        @(negedge CLK);
        chk("req_ready_after_midop_reset", REQ_READY, 1);
        run(32'h41, 0, 32'h0, 0, 0, 1'b1, memval(32'h41), 1);

        // Counter sequence from a clean reset: miss, hit, hit, write, miss.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_clear();
        @(negedge CLK);
        run(32'h10, 0, 32'h0,      0, 0, 1'b0, 32'h0, 0);
        run(32'h10, 0, 32'h0,      0, 0, 1'b0, 32'h0, 0);
        run(32'h10, 0, 32'h0,      1, 1, 1'b0, 32'h0, 0);
        run(32'h20, 1, 32'h0F0F0F0F, 0, 0, 1'b0, 32'h0, 0);
        run(32'h30, 0, 32'h0,      0, 0, 1'b0, 32'h0, 0);
`ifdef MEM_CACHE_STATS_EN
        chk("stats_hit_count", HIT_COUNT, 2);
        chk("stats_miss_count", MISS_COUNT, 2);
`endif

        for (int n = 0; n < 200; n++) begin
            a = (32'($urandom_range(0, 3)) << 6) | 32'($urandom_range(0, 7));
            run(a, ($urandom_range(0, 9) < 3), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                1'b0, 32'h0, 0);
        end
`ifdef MEM_CACHE_STATS_EN
        chk("final_hit_count", HIT_COUNT, m_hits);
        chk("final_miss_count", MISS_COUNT, m_misses);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_cache.md
Name: mem_cache

Overview:
- Direct-mapped, write-through, write-allocate word cache.
- Sits between the memory-access worker and the external memory port.
- Upstream side accepts the worker's address/data request handshake and returns one response word per request; downstream side issues word reads/writes to memory.
- Removes memory round-trips for repeated MA_PEEK addresses.

Parameters:
- INDEX_WIDTH, 6, number of index bits; the cache holds 2**INDEX_WIDTH one-word lines.
- ADDR_WIDTH, 32, word-address width; tag width = ADDR_WIDTH-INDEX_WIDTH.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- REQ_ADDR_VALID  in  1  request valid
- REQ_ADDR  in  ADDR_WIDTH  word address
- REQ_DATA_VALID  in  1  request is write (poke); sampled with REQ_ADDR
- REQ_DATA  in  32  write data
- REQ_READY  out  1  request accept
- RESP_VALID  out  1  response valid
- RESP_DATA  out  32  read data, or the written data for writes
- RESP_READY  in  1  response accept
- MEM_SEND_ADDR_VALID  out  1  memory request valid
- MEM_SEND_ADDR  out  ADDR_WIDTH  memory word address
- MEM_SEND_DATA_VALID  out  1  memory request is write
- MEM_SEND_DATA  out  32  memory write data
- MEM_SEND_READY  in  1  memory request accept
- MEM_RECEIVE_VALID  in  1  memory response valid (returned for reads and writes)
- MEM_RECEIVE_DATA  in  32  memory response word
- MEM_RECEIVE_READY  out  1  memory response accept

Behaviour:
- Clocking and reset: one clock CLK; reset RST is synchronous, active-high.
- Reset values: all outputs 0; all line valid bits 0; state S_IDLE.
- Reset mid-transaction abandons the transaction (no response); memory must tolerate the dropped handshake.
- Handshake rule: transfer occurs on a rising edge where valid && ready. Every registered VALID holds with stable payload until the transfer.
- Address split: index = REQ_ADDR[INDEX_WIDTH-1:0]; tag = REQ_ADDR[ADDR_WIDTH-1:INDEX_WIDTH].
- Request latch: addr, data, write flag and index are latched on REQ transfer.

State machine:
- S_IDLE:
  - REQ_READY registered high the cycle after entry.
  - On REQ transfer: REQ_READY drops next cycle; go to S_LOOKUP.
- S_LOOKUP (one cycle): compare tag and valid of the indexed line.
  - Read hit: load RESP_DATA from the line; go to S_RESP.
  - Read miss or any write: go to S_MEM_SEND.
- S_MEM_SEND:
  - MEM_SEND_ADDR_VALID high; MEM_SEND_DATA_VALID = latched write flag.
  - MEM_SEND_ADDR/MEM_SEND_DATA = latched values.
  - On transfer: go to S_MEM_RECEIVE.
- S_MEM_RECEIVE:
  - MEM_RECEIVE_READY high only in this state.
  - On transfer, line[index] <= {valid=1, tag, word}, where word = MEM_RECEIVE_DATA for reads and the latched REQ_DATA for writes.
  - RESP_DATA <= same word; go to S_RESP.
- S_RESP:
  - RESP_VALID high until RESP_READY transfer, then back to S_IDLE.

Latency:
- Read hit: RESP_VALID rises 2 cycles after the REQ transfer edge.
- Miss/write: 2 cycles plus memory handshake time.

Boundary conditions:
- Strictly one outstanding request; REQ_READY is low outside S_IDLE.
- Write to a valid line with a different tag overwrites it (no write-back needed).
- MEM_RECEIVE_VALID arriving before MEM_SEND transfer is not accepted.
- RESP_READY held low stalls indefinitely with no state loss.
- Back-to-back requests: the next REQ_READY rises the cycle after the RESP transfer.

Optional Feature:
- Macro: MEM_CACHE_STATS_EN.
- When defined, adds output ports HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - Both reset to 0.
  - In S_LOOKUP, a read hit increments HIT_COUNT; a read miss increments MISS_COUNT.
  - Writes count in neither.
  - Both counters saturate at 32'hFFFFFFFF.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Read miss then read hit:
  - Read 0x41; memory returns 0xDEADBEEF, RESP_DATA=0xDEADBEEF with exactly one MEM_SEND.
  - Re-read 0x41: RESP_VALID 2 cycles after accept, RESP_DATA=0xDEADBEEF, no MEM_SEND.
- Write-through:
  - Write 0x41 <= 0x12345678: MEM_SEND_ADDR=0x41, DATA_VALID=1, DATA=0x12345678; RESP_DATA=0x12345678.
  - Then read 0x41: hit, returns 0x12345678, no memory traffic.
- Conflict eviction:
  - Read 0x01 (mem 0xAAAA), then read 0x41 (same index 1, mem 0xBBBB), then read 0x01.
  - Required: third access misses and issues MEM_SEND_ADDR=0x01.
- Backpressure:
  - Hold MEM_SEND_READY low 5 cycles and RESP_READY low 4 cycles.
  - Required: MEM_SEND_ADDR_VALID/ADDR and RESP_VALID/RESP_DATA stay stable; exactly one transfer each.
- Reset mid-operation:
  - Assert RST during S_MEM_RECEIVE after a hit-filled line at 0x41.
  - Required: all outputs 0 next cycle; subsequent read 0x41 misses.
- Stats (MEM_CACHE_STATS_EN):
  - Sequence miss, hit, hit, write, miss.
  - Required: HIT_COUNT=2, MISS_COUNT=2.
